// File: rtl/count_display_decoder.sv
// Synchronises and debounces a 4-bit asynchronous count, converts it to BCD and drives a
// two-digit multiplexed common-anode 7-segment display with blanking and zero suppression.
module count_display_decoder #(
  parameter int unsigned SCAN_DIV   = 125000,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned BLANK_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] value_out,
  output logic       bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       update
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [PW-1:0] PresMax  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BlankLim = PW'(BLANK_CYC);
  localparam logic [SW-1:0] StabMax  = SW'(STABLE_CNT - 1);

  typedef enum logic {StOnes, StTens} scan_e;

  logic [3:0]    s1_q, s2_q;
  logic [3:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0]    value_q, value_d;
  logic          update_q, update_d;
  logic [PW-1:0] presc_q, presc_d;
  scan_e         state_q, state_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stab_q   <= '0;
      value_q  <= '0;
      update_q <= 1'b0;
      presc_q  <= '0;
      state_q  <= StOnes;
      seg_q    <= 7'h7F;
      an_q     <= 2'b11;
    end else begin
      s1_q     <= cnt_in;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      value_q  <= value_d;
      update_q <= update_d;
      presc_q  <= presc_d;
      state_q  <= state_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bcd_tens = (value_q >= 4'd10);
  assign bcd_ones = bcd_tens ? (value_q - 4'd10) : value_q;

  // Debounce: a candidate must stay put for STABLE_CNT samples before it is accepted.
  always_comb begin
    cand_d   = cand_q;
    stab_d   = stab_q;
    value_d  = value_q;
    update_d = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = '0;
    end else if (stab_q < StabMax) begin
      stab_d = stab_q + 1'b1;
    end else if (cand_q != value_q) begin
      value_d  = cand_q;
      update_d = 1'b1;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    state_d = state_q;
    if (presc_q == PresMax) begin
      presc_d = '0;
      state_d = (state_q == StOnes) ? StTens : StOnes;
    end
  end

  // Display register reflects the current slot; it lags the prescaler by one cycle.
  always_comb begin
    seg_d = 7'h7F;
    an_d  = 2'b11;
    if (!(presc_q < BlankLim)) begin
      case (state_q)
        StOnes: begin
          an_d  = 2'b10;
          seg_d = seg_pat(bcd_ones);
        end
        StTens: begin
          if (bcd_tens) begin
            an_d  = 2'b01;
            seg_d = seg_pat(4'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign value_out = value_q;
  assign update    = update_q;

endmodule

// File: tb/tb_count_display_decoder.sv
// Directed table-driven bench for count_display_decoder with SCAN_DIV=8, STABLE_CNT=4,
// BLANK_CYC=2; display checks count (an, seg) combinations over one full 16-cycle scan.
module tb_count_display_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] value_out;
  logic       bcd_tens;
  logic [3:0] bcd_ones;
  logic       update;

  int n_vec = 0;
  int n_err = 0;

  count_display_decoder #(
    .SCAN_DIV  (8),
    .STABLE_CNT(4),
    .BLANK_CYC (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .seg      (seg),
    .an       (an),
    .value_out(value_out),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .update   (update)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic [3:0] val;
    logic       tens;
    logic [3:0] ones;
    logic [6:0] seg_ones;
    int         upd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_count_updates(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (update) cnt++;
    end
  endtask

  task automatic scan_check(input string tag, input logic [6:0] seg_ones, input logic tens);
    int ones_lit = 0, tens_lit = 0, blank = 0, other = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an == 2'b10 && seg == seg_ones) ones_lit++;
      else if (an == 2'b01 && seg == 7'h79) tens_lit++;
      else if (an == 2'b11 && seg == 7'h7F) blank++;
      else other++;
    end
    check({tag, " ones_lit"}, ones_lit, 6);
    check({tag, " tens_lit"}, tens_lit, tens ? 6 : 0);
    check({tag, " blank"}, blank, tens ? 4 : 10);
    check({tag, " other"}, other, 0);
  endtask

  initial begin
    int ucnt;
    bit found;

    vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0, 7'h40, 1};
    vecs[1] = '{4'd7,  4'd7,  1'b0, 4'd7, 7'h78, 1};
    vecs[2] = '{4'd13, 4'd13, 1'b1, 4'd3, 7'h30, 1};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 4'd5, 7'h12, 1};
    vecs[4] = '{4'd0,  4'd0,  1'b0, 4'd0, 7'h40, 1};
    vecs[5] = '{4'd9,  4'd9,  1'b0, 4'd9, 7'h10, 1};
    vecs[6] = '{4'd9,  4'd9,  1'b0, 4'd9, 7'h10, 0};
    vecs[7] = '{4'd10, 4'd10, 1'b1, 4'd0, 7'h40, 1};
    vecs[8] = '{4'd4,  4'd4,  1'b0, 4'd4, 7'h19, 1};

    // Reset state, then acceptance latency of a change presented before edge 1.
    rst    = 1'b0;
    cnt_in = 4'd0;
    #12;
    check("reset seg", seg, 7'h7F);
    check("reset an", an, 2'b11);
    check("reset value_out", value_out, 0);
    check("reset update", update, 0);
    cnt_in = 4'd7;
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("latency update e%0d", e), update, (e == 7) ? 1 : 0);
      check($sformatf("latency value e%0d", e), value_out, (e >= 7) ? 7 : 0);
      if (e <= 2) check($sformatf("blank an e%0d", e), an, 2'b11);
      if (e == 3) begin
        check("first ones an", an, 2'b10);
        check("first ones seg", seg, 7'h40);
      end
    end

    // Short excursion is rejected; a long hold is accepted with a single pulse.
    cnt_in = 4'd2;
    repeat (3) tick();
    cnt_in = 4'd7;
    run_count_updates(12, ucnt);
    check("glitch updates", ucnt, 0);
    check("glitch value", value_out, 7);
    cnt_in = 4'd2;
    run_count_updates(10, ucnt);
    check("hold updates", ucnt, 1);
    check("hold value", value_out, 2);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("v%0d(%0d)", i, vecs[i].cnt);
      cnt_in = vecs[i].cnt;
      run_count_updates(12, ucnt);
      check({tag, " updates"}, ucnt, vecs[i].upd);
      check({tag, " value_out"}, value_out, vecs[i].val);
      check({tag, " bcd_tens"}, bcd_tens, vecs[i].tens);
      check({tag, " bcd_ones"}, bcd_ones, vecs[i].ones);
      scan_check(tag, vecs[i].seg_ones, vecs[i].tens);
    end

    // Asynchronous reset in the middle of a lit tens slot.
    cnt_in = 4'd13;
    run_count_updates(12, ucnt);
    check("pre-reset value", value_out, 13);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (an == 2'b01) found = 1'b1;
    end
    check("tens slot reached", found, 1);
    #2;
    rst = 1'b0;
    #1;
    check("midreset seg", seg, 7'h7F);
    check("midreset an", an, 2'b11);
    check("midreset value", value_out, 0);
    check("midreset update", update, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rerun update e%0d", e), update, (e == 7) ? 1 : 0);
      check($sformatf("rerun value e%0d", e), value_out, (e == 7) ? 13 : 0);
      if (e <= 2) check($sformatf("rerun blank e%0d", e), an, 2'b11);
      if (e == 3) begin
        check("rerun ones an", an, 2'b10);
        check("rerun ones seg", seg, 7'h40);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
